req_priority_encoder: RTL and testbench

- Sequential N-to-log2(N) priority encoder. It is the encode-side counterpart of the team's 3-to-8 one-hot decoder.
- Latches event pulses on N request lines into a sticky pending register.
- Presents the binary index of the selected pending request on a valid/ready output port.
- Code k corresponds to one-hot bit k, so the downstream 3-to-8 decoder reproduces the granted line.

---
 rtl/req_priority_encoder_if.sv | 25 ++
 rtl/req_priority_encoder.sv | 111 +++++++++++
 tb/tb_req_priority_encoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/req_priority_encoder_if.sv
// Request/grant bundle for req_priority_encoder: event inputs, mask, and the
// valid/ready code port with its pending/overflow status.
interface req_priority_encoder_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         code_valid;
  logic [W-1:0] code;
  logic         code_ready;
  logic [N-1:0] pending;
  logic         overflow;

  modport master (
    output req, mask, code_ready,
    input  code_valid, code, pending, overflow
  );

  modport slave (
    input  req, mask, code_ready,
    output code_valid, code, pending, overflow
  );
endinterface

// File: rtl/req_priority_encoder.sv
// Sticky-pending N-to-log2(N) priority encoder with a valid/ready code port.
// Define REQ_PRIORITY_ENC_RR_EN for rotating (last-grant) priority; default is fixed, highest index wins.
//
// state      | meaning
// ST_IDLE    | no code presented, waiting for an eligible pending line
// ST_PRESENT | code holds a granted index, waiting for code_ready
module req_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input logic                   clk,
  input logic                   rst_n,
  req_priority_encoder_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         overflow_q, overflow_d;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic         any_elig;
  logic         load;

  assign elig     = pending_q & ~bus.mask;
  assign any_elig = |elig;

`ifdef REQ_PRIORITY_ENC_RR_EN
  logic [W-1:0] last_q, last_d;

  // Walk from farthest to nearest so the line right after last_q wins.
  always_comb begin
    sel = '0;
    for (int k = N; k >= 1; k--) begin
      if (elig[last_q + W'(k)]) sel = last_q + W'(k);
    end
  end

  always_comb begin
    last_d = last_q;
    if (load) last_d = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= W'(N - 1);
    else        last_q <= last_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) sel = W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          load    = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.code_ready) begin
          if (any_elig) load = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_d = code_q;
    clr    = '0;
    if (load) begin
      code_d   = sel;
      clr[sel] = 1'b1;
    end
    // A new event on the line being cleared re-pends rather than coalescing.
    pending_d  = (pending_q & ~clr) | bus.req;
    overflow_d = |(bus.req & pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      code_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.code_valid = (state_q == ST_PRESENT);
  assign bus.code       = code_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Self-checking bench for req_priority_encoder: directed scenarios plus random
// traffic compared against a per-line behavioural model.
module tb_req_priority_encoder;
  localparam int N = 8;

  logic clk;
  logic rst_n;

  req_priority_encoder_if #(.N(N)) bus ();

  req_priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt  = 0;
  int grants[$];

  bit m_pend[N];
  bit m_valid;
  int m_code;
  int m_last;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_code  = 0;
    m_last  = N - 1;
    m_ovf   = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] m);
`ifdef REQ_PRIORITY_ENC_RR_EN
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (m_pend[i] && !m[i]) return i;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i] && !m[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy);
    int p;
    bit ld;
    bit ov;
    p  = pick(m);
    ld = (p >= 0) && (!m_valid || rdy);
    ov = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r[i] && m_pend[i] && !(ld && i == p)) ov = 1'b1;
    end
    if (ld) m_pend[p] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) m_pend[i] = 1'b1;
    end
    if (ld) begin
      m_valid = 1'b1;
      m_code  = p;
      m_last  = p;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovf = ov;
  endtask

  task automatic compare_all();
    chk("valid",    32'(bus.code_valid), 32'(m_valid));
    chk("code",     32'(bus.code),       32'(m_code));
    chk("pending",  32'(bus.pending),    32'(m_pend_vec()));
    chk("overflow", 32'(bus.overflow),   32'(m_ovf));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy);
    @(negedge clk);
    compare_all();
    if (bus.overflow) ov_cnt++;
    if (bus.code_valid && rdy) grants.push_back(int'(bus.code));
    bus.req        = r;
    bus.mask       = m;
    bus.code_ready = rdy;
    model_step(r, m, rdy);
  endtask

  // Grant history packed as nibbles behind a leading 1, e.g. 7,2,0 -> 'h1720.
  function automatic logic [31:0] packed_grants();
    logic [31:0] v;
    v = 32'h1;
    foreach (grants[i]) v = (v << 4) | 32'(grants[i]);
    return v;
  endfunction

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] m;
    logic         rdy;

    rst_n          = 1'b0;
    bus.req        = 8'hFF;
    bus.mask       = '0;
    bus.code_ready = 1'b0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      chk("rst_valid",   32'(bus.code_valid), 32'd0);
      chk("rst_pending", 32'(bus.pending),    32'd0);
      chk("rst_ovf",     32'(bus.overflow),   32'd0);
      chk("rst_code",    32'(bus.code),       32'd0);
    end
    bus.req = '0;
    rst_n   = 1'b1;
    repeat (3) cycle(8'h00, 8'h00, 1'b1);

    // Single event, two-cycle latency
    grants.delete();
    cycle(8'h10, 8'h00, 1'b1);
    cycle(8'h00, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("single_valid", 32'(bus.code_valid), 32'd1);
    chk("single_code",  32'(bus.code),       32'd4);
    repeat (2) cycle(8'h00, 8'h00, 1'b1);
    chk("single_pend",   32'(bus.pending), 32'd0);
    chk("single_grants", packed_grants(),  32'h14);

    // Drain with backpressure
    grants.delete();
    cycle(8'h85, 8'h00, 1'b0);
    repeat (6) cycle(8'h00, 8'h00, 1'b0);
    chk("bp_hold_valid", 32'(bus.code_valid), 32'd1);
    chk("bp_hold_code",  32'(bus.code),       32'd7);
    repeat (5) cycle(8'h00, 8'h00, 1'b1);
    chk("bp_idle", 32'(bus.code_valid), 32'd0);
`ifdef REQ_PRIORITY_ENC_RR_EN
    chk("bp_grants", packed_grants(), 32'h1702);
`else
    chk("bp_grants", packed_grants(), 32'h1720);
`endif

    // Masked line coalesces
    grants.delete();
    ov_cnt = 0;
    cycle(8'h80, 8'h80, 1'b1);
    repeat (2) cycle(8'h00, 8'h80, 1'b1);
    cycle(8'h80, 8'h80, 1'b1);
    repeat (3) cycle(8'h00, 8'h80, 1'b1);
    chk("mask_pend",  32'(bus.pending),    32'h80);
    chk("mask_ovf",   32'(ov_cnt),         32'd1);
    chk("mask_valid", 32'(bus.code_valid), 32'd0);
    repeat (4) cycle(8'h00, 8'h00, 1'b1);
    chk("mask_grants", packed_grants(), 32'h17);

    // Set and clear on the same bit
    grants.delete();
    ov_cnt = 0;
    cycle(8'h20, 8'h00, 1'b1);
    cycle(8'h20, 8'h00, 1'b1);
    repeat (4) cycle(8'h00, 8'h00, 1'b1);
    chk("sc_grants", packed_grants(), 32'h155);
    chk("sc_ovf",    32'(ov_cnt),     32'd0);

    // Async reset while presenting
    cycle(8'h08, 8'h00, 1'b0);
    repeat (2) cycle(8'h00, 8'h00, 1'b0);
    chk("arst_pre", 32'(bus.code_valid), 32'd1);
    #2;
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.mask       = '0;
    bus.code_ready = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.code_valid), 32'd0);
    chk("arst_pend",  32'(bus.pending),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Priority order after reset, two rounds
    grants.delete();
    cycle(8'h81, 8'h00, 1'b1);
    repeat (4) cycle(8'h00, 8'h00, 1'b1);
    cycle(8'h81, 8'h00, 1'b1);
    repeat (4) cycle(8'h00, 8'h00, 1'b1);
`ifdef REQ_PRIORITY_ENC_RR_EN
    chk("order_grants", packed_grants(), 32'h10707);
`else
    chk("order_grants", packed_grants(), 32'h17070);
`endif

    // Random traffic against the model
    repeat (600) begin
      r   = N'($urandom & $urandom & $urandom);
      m   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, m, rdy);
    end
    repeat (20) cycle(8'h00, 8'h00, 1'b1);
    @(negedge clk);
    compare_all();
    chk("drain_pend", 32'(bus.pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
